// File: rtl/stage_two.sv
// rtl/stage_two.sv - execute stage: single-cycle ALU plus 16-iteration sequential MUL/DIV engine
// Optional STAGE_TWO_FAST_MUL_EN: MUL uses a combinational multiplier and completes in one cycle.
module stage_two #(
  parameter int ITER  = 16,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_sys,
  input  logic               in_valid,
  input  logic [1:0]         in_memc,
  input  logic               in_reg_wr,
  input  logic [WIDTH-1:0]   in_alu_a,
  input  logic [WIDTH-1:0]   in_alu_b,
  input  logic [WIDTH-1:0]   in_R1_data,
  input  logic               in_R0_en,
  input  logic [3:0]         in_alu_ctrl,
  input  logic [15:0]        in_instr,
  output logic               busy,
  output logic [2*WIDTH-1:0] aluout,
  output logic               out_valid,
  output logic [1:0]         out_memc,
  output logic               out_reg_wr,
  output logic [2*WIDTH-1:0] out_alu,
  output logic [WIDTH-1:0]   out_R1_data,
  output logic               out_R0_en,
  output logic [15:0]        out_instr,
  output logic               div0,
  output logic               overflow
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic              neg_p_q, neg_p_d, neg_r_q, neg_r_d;
  logic              op_div_q, op_div_d, ovf_pend_q, ovf_pend_d;
  logic [1:0]        memc_q, memc_d;
  logic              reg_wr_q, reg_wr_d, r0_q, r0_d;
  logic [WIDTH-1:0]  r1_q, r1_d;
  logic [15:0]       instr_q, instr_d;

  logic               valid_d, oreg_wr_d, or0_d, div0_d, ovf_d;
  logic [1:0]         omemc_d;
  logic [2*WIDTH-1:0] alu_d;
  logic [WIDTH-1:0]   or1_d;
  logic [15:0]        oinstr_d;

  logic [2*WIDTH-1:0] sc_res, dbl;
  logic               sc_ovf;
  logic [WIDTH-1:0]   sum;
  logic signed [WIDTH-1:0] sra_v;
  logic [3:0]         sh;

  logic [WIDTH:0]     mul_sum, div_t;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff, q_fix, r_fix;
  logic [2*WIDTH-1:0] p_fix;
  logic               launch;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign busy   = (state_q != IDLE);
  assign aluout = out_alu;
  assign sh     = in_alu_b[3:0];

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sum    = '0;
    dbl    = {in_alu_a, in_alu_a};
    sra_v  = $signed(in_alu_a) >>> sh;
    case (in_alu_ctrl)
      OP_ADD: begin
        sum    = in_alu_a + in_alu_b;
        sc_res = {{WIDTH{1'b0}}, sum};
        sc_ovf = (in_alu_a[WIDTH-1] == in_alu_b[WIDTH-1]) && (sum[WIDTH-1] != in_alu_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum    = in_alu_a - in_alu_b;
        sc_res = {{WIDTH{1'b0}}, sum};
        sc_ovf = (in_alu_a[WIDTH-1] != in_alu_b[WIDTH-1]) && (sum[WIDTH-1] != in_alu_a[WIDTH-1]);
      end
      OP_AND: sc_res = {{WIDTH{1'b0}}, in_alu_a & in_alu_b};
      OP_OR:  sc_res = {{WIDTH{1'b0}}, in_alu_a | in_alu_b};
      OP_SLL: sc_res = {{WIDTH{1'b0}}, in_alu_a << sh};
      OP_SRL: sc_res = {{WIDTH{1'b0}}, in_alu_a >> sh};
      OP_SRA: sc_res = {{WIDTH{1'b0}}, sra_v};
      // Rotates shift a doubled copy so the wrapped bits come along for free.
      OP_ROL: begin
        dbl    = dbl << sh;
        sc_res = {{WIDTH{1'b0}}, dbl[2*WIDTH-1:WIDTH]};
      end
      OP_ROR: begin
        dbl    = dbl >> sh;
        sc_res = {{WIDTH{1'b0}}, dbl[WIDTH-1:0]};
      end
`ifdef STAGE_TWO_FAST_MUL_EN
      OP_MUL: sc_res = {{WIDTH{in_alu_a[WIDTH-1]}}, in_alu_a} * {{WIDTH{in_alu_b[WIDTH-1]}}, in_alu_b};
`endif
      default: sc_res = '0;
    endcase
  end

  // Engine works on magnitudes; signs are reapplied when the result is delivered.
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign div_t    = {hi_q, lo_q[WIDTH-1]};
  assign div_ge   = (div_t >= {1'b0, m_q});
  assign div_diff = div_t[WIDTH-1:0] - m_q;
  assign q_fix    = neg_p_q ? -lo_q : lo_q;
  assign r_fix    = neg_r_q ? -hi_q : hi_q;
  assign p_fix    = neg_p_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    neg_p_d    = neg_p_q;
    neg_r_d    = neg_r_q;
    op_div_d   = op_div_q;
    ovf_pend_d = ovf_pend_q;
    memc_d     = memc_q;
    reg_wr_d   = reg_wr_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    instr_d    = instr_q;
    valid_d    = 1'b0;
    oreg_wr_d  = 1'b0;
    omemc_d    = out_memc;
    alu_d      = out_alu;
    or1_d      = out_R1_data;
    or0_d      = out_R0_en;
    oinstr_d   = out_instr;
    div0_d     = div0;
    ovf_d      = overflow;
    launch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_alu_ctrl == OP_DIV && in_alu_b != '0) begin
            launch     = 1'b1;
            state_d    = DIV;
            lo_d       = mag(in_alu_a);
            m_d        = mag(in_alu_b);
            neg_p_d    = in_alu_a[WIDTH-1] ^ in_alu_b[WIDTH-1];
            neg_r_d    = in_alu_a[WIDTH-1];
            op_div_d   = 1'b1;
            ovf_pend_d = (in_alu_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_alu_b == '1);
          end
`ifndef STAGE_TWO_FAST_MUL_EN
          else if (in_alu_ctrl == OP_MUL) begin
            launch     = 1'b1;
            state_d    = MUL;
            lo_d       = mag(in_alu_b);
            m_d        = mag(in_alu_a);
            neg_p_d    = in_alu_a[WIDTH-1] ^ in_alu_b[WIDTH-1];
            neg_r_d    = 1'b0;
            op_div_d   = 1'b0;
            ovf_pend_d = 1'b0;
          end
`endif
          else begin
            valid_d   = 1'b1;
            oreg_wr_d = in_reg_wr;
            omemc_d   = in_memc;
            or1_d     = in_R1_data;
            or0_d     = in_R0_en;
            oinstr_d  = in_instr;
            alu_d     = sc_res;
            if (in_alu_ctrl == OP_DIV) div0_d = 1'b1;
            if (sc_ovf) ovf_d = 1'b1;
          end
        end
      end
      MUL: begin
        hi_d  = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DIV: begin
        hi_d  = div_ge ? div_diff : div_t[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        valid_d   = 1'b1;
        oreg_wr_d = reg_wr_q;
        omemc_d   = memc_q;
        or1_d     = r1_q;
        or0_d     = r0_q;
        oinstr_d  = instr_q;
        alu_d     = op_div_q ? {r_fix, q_fix} : p_fix;
        if (ovf_pend_q) ovf_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      cnt_d    = '0;
      hi_d     = '0;
      memc_d   = in_memc;
      reg_wr_d = in_reg_wr;
      r0_d     = in_R0_en;
      r1_d     = in_R1_data;
      instr_d  = in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      m_q         <= '0;
      neg_p_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      op_div_q    <= 1'b0;
      ovf_pend_q  <= 1'b0;
      memc_q      <= '0;
      reg_wr_q    <= 1'b0;
      r0_q        <= 1'b0;
      r1_q        <= '0;
      instr_q     <= '0;
      out_valid   <= 1'b0;
      out_memc    <= '0;
      out_reg_wr  <= 1'b0;
      out_alu     <= '0;
      out_R1_data <= '0;
      out_R0_en   <= 1'b0;
      out_instr   <= '0;
      div0        <= 1'b0;
      overflow    <= 1'b0;
    end else if (!halt_sys) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      m_q         <= m_d;
      neg_p_q     <= neg_p_d;
      neg_r_q     <= neg_r_d;
      op_div_q    <= op_div_d;
      ovf_pend_q  <= ovf_pend_d;
      memc_q      <= memc_d;
      reg_wr_q    <= reg_wr_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      instr_q     <= instr_d;
      out_valid   <= valid_d;
      out_memc    <= omemc_d;
      out_reg_wr  <= oreg_wr_d;
      out_alu     <= alu_d;
      out_R1_data <= or1_d;
      out_R0_en   <= or0_d;
      out_instr   <= oinstr_d;
      div0        <= div0_d;
      overflow    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_stage_two.sv
// tb/tb_stage_two.sv - self-checking bench for stage_two: vector table, corner sequences, random vs model
module tb_stage_two;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_ROR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_DIV = 4'd10;
`ifdef STAGE_TWO_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 18;
`endif
  localparam int DIV_LAT = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt_sys = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_memc = '0;
  logic        in_reg_wr = 1'b0;
  logic [15:0] in_alu_a = '0;
  logic [15:0] in_alu_b = '0;
  logic [15:0] in_R1_data = '0;
  logic        in_R0_en = 1'b0;
  logic [3:0]  in_alu_ctrl = '0;
  logic [15:0] in_instr = '0;
  logic        busy, out_valid, out_reg_wr, out_R0_en, div0, overflow;
  logic [31:0] aluout, out_alu;
  logic [1:0]  out_memc;
  logic [15:0] out_R1_data, out_instr;

  stage_two dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid),
    .in_memc(in_memc), .in_reg_wr(in_reg_wr), .in_alu_a(in_alu_a), .in_alu_b(in_alu_b),
    .in_R1_data(in_R1_data), .in_R0_en(in_R0_en), .in_alu_ctrl(in_alu_ctrl), .in_instr(in_instr),
    .busy(busy), .aluout(aluout), .out_valid(out_valid), .out_memc(out_memc),
    .out_reg_wr(out_reg_wr), .out_alu(out_alu), .out_R1_data(out_R1_data),
    .out_R0_en(out_R0_en), .out_instr(out_instr), .div0(div0), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int  passed = 0;
  int  total  = 0;
  bit  exp_ovf = 1'b0;
  bit  exp_dz  = 1'b0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    bit          ovf;
    bit          dz;
    int          lat;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: results straight from the arithmetic definitions.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] res, output bit ovf, output bit dz, output int lat);
    int sa, sb, ua, s, r, sh;
    longint p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    sh = b[3:0];
    res = '0; ovf = 1'b0; dz = 1'b0; lat = 1;
    case (op)
      OP_ADD: begin s = sa + sb; res = s & 'hFFFF; ovf = (s > 32767) || (s < -32768); end
      OP_SUB: begin s = sa - sb; res = s & 'hFFFF; ovf = (s > 32767) || (s < -32768); end
      OP_AND: res = ua & int'(b);
      OP_OR:  res = ua | int'(b);
      OP_SLL: res = (ua << sh) & 'hFFFF;
      OP_SRL: res = ua >> sh;
      OP_SRA: res = (sa >>> sh) & 'hFFFF;
      OP_ROL: res = ((ua << sh) | (ua >> (16 - sh))) & 'hFFFF;
      OP_ROR: res = ((ua >> sh) | (ua << (16 - sh))) & 'hFFFF;
      OP_MUL: begin p = longint'(sa) * longint'(sb); res = p[31:0]; lat = MUL_LAT; end
      OP_DIV: begin
        if (b == 16'h0000) dz = 1'b1;
        else begin
          s = sa / sb;
          r = sa % sb;
          res = {r[15:0], s[15:0]};
          ovf = (s > 32767);
          lat = DIV_LAT;
        end
      end
      default: res = '0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_res, input bit ovf_set, input bit dz_set, input int exp_lat,
                       input int halt_at, input int halt_len);
    logic [1:0]  memc;
    logic        rw, r0;
    logic [15:0] r1, ins;
    int          n, bc;
    memc = 2'($urandom); rw = 1'($urandom); r0 = 1'($urandom);
    r1 = 16'($urandom); ins = 16'($urandom);
    in_valid = 1'b1; in_alu_ctrl = op; in_alu_a = a; in_alu_b = b;
    in_memc = memc; in_reg_wr = rw; in_R0_en = r0; in_R1_data = r1; in_instr = ins;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_alu_a = 16'($urandom); in_alu_b = 16'($urandom);
    in_instr = 16'($urandom); in_reg_wr = ~rw; in_R1_data = ~r1;
    n = 1; bc = 0;
    @(negedge clk);
    while (!out_valid && n < 80) begin
      if (busy) bc++;
      if (n == halt_at) halt_sys = 1'b1;
      if (n == halt_at + halt_len) halt_sys = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    halt_sys = 1'b0;
    exp_ovf = exp_ovf | ovf_set;
    exp_dz  = exp_dz | dz_set;
    check({tag, " out_alu"}, out_alu, exp_res);
    check({tag, " aluout"}, aluout, exp_res);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_cycles"}, bc, exp_lat - 1);
    check({tag, " busy_at_result"}, busy, 1'b0);
    check({tag, " out_reg_wr"}, out_reg_wr, rw);
    check({tag, " out_instr"}, out_instr, ins);
    check({tag, " passthru"}, {out_memc, out_R0_en, out_R1_data}, {memc, r0, r1});
    check({tag, " overflow"}, overflow, exp_ovf);
    check({tag, " div0"}, div0, exp_dz);
  endtask

  initial begin
    logic [31:0] mres;
    bit          movf, mdz;
    int          mlat;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    tbl[0]  = '{OP_ADD, 16'h0003, 16'h0004, 32'h0000_0007, 1'b0, 1'b0, 1};
    tbl[1]  = '{OP_ADD, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b1, 1'b0, 1};
    tbl[2]  = '{OP_SUB, 16'h0005, 16'h0007, 32'h0000_FFFE, 1'b0, 1'b0, 1};
    tbl[3]  = '{OP_AND, 16'hF0F0, 16'hFF00, 32'h0000_F000, 1'b0, 1'b0, 1};
    tbl[4]  = '{OP_OR,  16'hF0F0, 16'h0F0F, 32'h0000_FFFF, 1'b0, 1'b0, 1};
    tbl[5]  = '{OP_SLL, 16'h1234, 16'h0004, 32'h0000_2340, 1'b0, 1'b0, 1};
    tbl[6]  = '{OP_SRL, 16'h8000, 16'h000F, 32'h0000_0001, 1'b0, 1'b0, 1};
    tbl[7]  = '{OP_SRA, 16'h8000, 16'h0003, 32'h0000_F000, 1'b0, 1'b0, 1};
    tbl[8]  = '{OP_ROL, 16'h8001, 16'h0001, 32'h0000_0003, 1'b0, 1'b0, 1};
    tbl[9]  = '{OP_ROR, 16'h0001, 16'h0001, 32'h0000_8000, 1'b0, 1'b0, 1};
    tbl[10] = '{OP_ROR, 16'h1234, 16'h0010, 32'h0000_1234, 1'b0, 1'b0, 1};
    tbl[11] = '{OP_MUL, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 1'b0, 1'b0, MUL_LAT};
    tbl[12] = '{OP_MUL, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0, MUL_LAT};
    tbl[13] = '{OP_DIV, 16'hFFF9, 16'h0002, 32'hFFFF_FFFD, 1'b0, 1'b0, DIV_LAT};
    tbl[14] = '{OP_DIV, 16'h0005, 16'h0000, 32'h0000_0000, 1'b0, 1'b1, 1};
    tbl[15] = '{OP_DIV, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b1, 1'b0, DIV_LAT};
    tbl[16] = '{OP_SUB, 16'h8000, 16'h0001, 32'h0000_7FFF, 1'b1, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_alu", out_alu, 32'h0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset flags", {div0, overflow}, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset while a divide is in flight: nothing may come out of it.
    in_valid = 1'b1; in_alu_ctrl = OP_DIV; in_alu_a = 16'hFFF9; in_alu_b = 16'h0002;
    in_instr = 16'hABCD; in_reg_wr = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset out_alu", out_alu, 32'h0);
    check("midreset busy", busy, 1'b0);
    check("midreset ctrl", {out_valid, out_reg_wr, out_instr}, 18'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset no late result", {out_valid, busy}, 2'b00);
    issue("post_reset_add", OP_ADD, 16'h0003, 16'h0004, 32'h7, 1'b0, 1'b0, 1, 0, 0);

    for (int i = 0; i < 17; i++) begin
      issue($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
            tbl[i].ovf, tbl[i].dz, tbl[i].lat, 0, 0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d bubble", i), {out_valid, out_reg_wr}, 2'b00);
    end

    for (int i = 0; i < 10; i++)
      issue($sformatf("sticky_add%0d", i), OP_ADD, 16'(i), 16'(i), 32'(2 * i), 1'b0, 1'b0, 1, 0, 0);

    issue("halt_mul", OP_MUL, 16'h0123, 16'hFF00, 32'hFFFE_DD00, 1'b0, 1'b0,
          (MUL_LAT == 1) ? 1 : MUL_LAT + 4, 3, 4);

    issue("b2b_div", OP_DIV, 16'd100, 16'd7, 32'h0002_000E, 1'b0, 1'b0, DIV_LAT, 0, 0);
    issue("b2b_sub", OP_SUB, 16'h0005, 16'h0007, 32'h0000_FFFE, 1'b0, 1'b0, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 10));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (rop == OP_DIV && $urandom_range(0, 5) == 0) rb = 16'h0000;
      if (rop == OP_DIV && $urandom_range(0, 7) == 0) begin ra = 16'h8000; rb = 16'hFFFF; end
      model(rop, ra, rb, mres, movf, mdz, mlat);
      issue($sformatf("rand%0d", i), rop, ra, rb, mres, movf, mdz, mlat, 0, 0);
    end

    rst = 1'b0;
    #1;
    check("final reset flags", {div0, overflow, out_valid}, 3'b000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stage_two.md
Name: stage_two

Overview:
Execute stage, directly downstream of stage_one. Consumes stage_one's flopped ALU operands and control, then computes the ALU result:
- single-cycle ops complete in one cycle;
- MUL and DIV run on a 16-iteration sequential engine.

It registers the result and passthrough control into the stage-two/stage-three pipeline register. It returns `aluout` to stage_one for forwarding and `busy` for stalling.

Parameters:
- ITER, 16: iterations of the sequential MUL/DIV engine; must equal the operand width.
- WIDTH, 16: datapath operand width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- halt_sys  in  1  freeze; all state holds while 1.
- in_valid  in  1  input slot holds a real instruction.
- in_memc  in  2  memory control {mem2r, memwr}, passthrough.
- in_reg_wr  in  1  register write enable, passthrough.
- in_alu_a  in  16  operand A.
- in_alu_b  in  16  operand B.
- in_R1_data  in  16  store data, passthrough.
- in_R0_en  in  1  R0 (high half) write enable, passthrough.
- in_alu_ctrl  in  4  control_e operation.
- in_instr  in  16  instruction, passthrough.
- busy  out  1  MUL/DIV in progress; stage_one must stall.
- aluout  out  32  equals out_alu; forwarding path.
- out_valid  out  1  registered valid.
- out_memc  out  2  registered.
- out_reg_wr  out  1  registered; forced 0 when out_valid=0.
- out_alu  out  32  result; [15:0] primary, [31:16] high product/remainder.
- out_R1_data  out  16  registered.
- out_R0_en  out  1  registered.
- out_instr  out  16  registered.
- div0  out  1  sticky divide-by-zero flag.
- overflow  out  1  sticky signed-overflow flag.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM to IDLE, iteration counter 0, sticky flags cleared. Abort any in-flight MUL/DIV; no result is produced.
- halt_sys=1: FSM, counter, datapath, outputs and flags all hold. Inputs are ignored.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, single-cycle op (ADD, SUB, AND, OR, SLL, SRL, SRA, ROL, ROR) with in_valid=1:
  - result and passthroughs are registered at the next edge (latency 1);
  - out_valid=1 and out_alu[31:16]=0.
- Arithmetic and shift rules:
  - ADD/SUB wrap modulo 2^16.
  - Signed overflow (operand signs agree, result sign differs; SUB uses negated B) sets `overflow`. The result is still written.
  - Shift amount is in_alu_b[3:0].
- IDLE, MUL/DIV with in_valid=1:
  - latch operands and passthroughs; go to MUL or DIV; counter=0; busy=1 from the following cycle;
  - the output register carries a bubble (out_valid=0, out_reg_wr=0) each busy cycle.
- MUL: signed 16x16 product, shift-add, one bit per cycle. Counter increments; at counter=ITER-1 go to DONE.
- DIV:
  - signed restoring division on magnitudes, one bit per cycle; DONE after ITER cycles;
  - quotient truncates toward zero; remainder takes the dividend's sign.
- DONE (one cycle):
  - out_alu = {high,low} product, or {remainder,quotient};
  - out_valid=1; busy=0; return to IDLE.
  - Total latency from issue edge to result edge: ITER+2 = 18 cycles.
- DIV with in_alu_b=0: no engine entry. Single-cycle result out_alu=0; div0 sets.
- DIV 0x8000 / 0xFFFF: quotient 0x8000, remainder 0; overflow sets.
- Inputs arriving while busy=1 are ignored; upstream holds them by stall.
- in_valid=0 in IDLE: bubble registered.
- div0 and overflow stay set until reset.

Optional Feature:
STAGE_TWO_FAST_MUL_EN
- Defined: MUL uses a combinational signed 16x16 multiplier and completes as a single-cycle op (latency 1, busy never asserted); the MUL state is unreachable.
- Undefined: MUL uses the sequential engine described above.
- DIV is sequential in both builds.

Test Plan:
- Reset mid-DIV: drop rst to 0 at cycle 5 of the DIV → all outputs 0, busy=0. After release, ADD 3+4 → out_alu=0x00000007 one cycle later.
- ADD 0x7FFF+0x0001 → out_alu=0x00008000, overflow=1, and overflow stays 1 through ten further ADDs.
- MUL 0xFFFD(-3) × 0x0007 → busy=1 for 17 cycles; out_alu=0xFFFFFFEB, out_valid=1 at cycle 18. With STAGE_TWO_FAST_MUL_EN: same value at cycle 1, busy=0.
- DIV 0xFFF9(-7) / 0x0002 → out_alu={0xFFFF,0xFFFD} at cycle 18; DIV 5/0 → out_alu=0, div0=1 at cycle 1, busy never 1.
- halt_sys=1 for 4 cycles during MUL → counter frozen; result arrives 4 cycles later than the unhalted case, with a correct value.
- SUB 0x0005-0x0007 issued back-to-back after a DIV completes → out_alu=0x0000FFFE, out_reg_wr follows in_reg_wr, out_instr equals in_instr.
